instr_mem_responder: RTL and testbench

- Memory-side responder for the instruction fetch bus: it accepts req/gnt address phases from the fetch stage and returns in-order rvalid/rdata/err responses after a fixed latency.
- Backed by a synchronous single-port word memory through a simple read port.
- Used in the core testbench and FPGA top to model and serve instruction memory.
- A grant-blocking input lets benches inject wait states.

---
 rtl/instr_mem_responder_if.sv | 37 +++
 rtl/instr_mem_responder.sv | 157 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// ---------------------------------------------------------------------------
// instr_mem_responder_if
//   Instruction fetch bus between a fetch stage (master) and an instruction
//   memory responder (slave).
//   instr_req    : address-phase request          (master -> slave)
//   instr_addr   : byte address of the request    (master -> slave)
//   instr_gnt    : address-phase accept           (slave  -> master)
//   instr_rvalid : response valid, one per grant  (slave  -> master)
//   instr_rdata  : response word                  (slave  -> master)
//   instr_err    : response error, with rvalid    (slave  -> master)
// ---------------------------------------------------------------------------
interface instr_mem_responder_if;
  logic        instr_req;
  logic        instr_gnt;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_rvalid;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rdata,
    input  instr_err,
    input  instr_rvalid
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rdata,
    output instr_err,
    output instr_rvalid
  );
endinterface

// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
//   Memory-side responder for the instruction fetch bus. Accepts req/gnt
//   address phases, reads a synchronous single-port word memory and returns
//   in-order rvalid/rdata/err responses exactly LATENCY cycles after grant.
//
//   clk          : clock, rising edge
//   rstn         : asynchronous active-low reset
//   bus (slave)  : fetch bus (req/addr in, gnt/rvalid/rdata/err out)
//   gnt_block_i  : forces gnt low to inject address-phase wait states
//   mem_en_o     : backing-memory read enable
//   mem_addr_o   : backing-memory word index
//   mem_rdata_i  : backing-memory data, valid the cycle after mem_en_o
// ---------------------------------------------------------------------------
module instr_mem_responder #(
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  instr_mem_responder_if.slave         bus,
  input  logic                         gnt_block_i,
  output logic                         mem_en_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned   AW        = $clog2(MEM_WORDS);
  localparam int unsigned   CW        = $clog2(MAX_OUTSTANDING + 32'd1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]   WORDS_C   = 32'(MEM_WORDS);

  // Reject illegal parameter combinations while elaborating.
  if ((MEM_WORDS < 32'd2) || (MEM_WORDS > 32'h4000_0000) ||
      ((MEM_WORDS & (MEM_WORDS - 32'd1)) != 32'd0)) begin : g_bad_words
    $error("instr_mem_responder: MEM_WORDS must be a power of two in 2..2^30");
  end
  if ((LATENCY < 32'd1) || (LATENCY > 32'd4)) begin : g_bad_latency
    $error("instr_mem_responder: LATENCY must be in 1..4");
  end
  if ((MAX_OUTSTANDING < 32'd1) || (MAX_OUTSTANDING > LATENCY + 32'd1)) begin : g_bad_outstanding
    $error("instr_mem_responder: MAX_OUTSTANDING must be in 1..LATENCY+1");
  end

  // One in-flight request: err slots never touch memory, idx is only
  // meaningful for valid, non-err slots.
  typedef struct packed {
    logic          valid;
    logic          err;
    logic [AW-1:0] idx;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{valid: 1'b0, err: 1'b0, idx: {AW{1'b0}}};

  logic          gnt_s;
  logic          xfer_s;
  logic          in_range_s;
  logic [31:0]   offset_s;
  logic [31:0]   word_off_s;
  logic          rsp_valid_s;
  logic          rsp_err_s;
  slot_t         stage0_s;
  slot_t         rd_slot_s;
  slot_t         slot_q [LATENCY:1];
  slot_t         slot_d [LATENCY:1];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Grant from the registered outstanding count and decode of the address.
  always_comb begin
    gnt_s      = bus.instr_req & ~gnt_block_i & (cnt_q < MAX_OUT_C);
    xfer_s     = bus.instr_req & gnt_s;
    // Wrapping 32-bit subtraction; addresses below MEM_BASE are caught by
    // the explicit compare, so the wrapped offset never matters.
    offset_s   = bus.instr_addr - MEM_BASE;
    word_off_s = offset_s >> 5'd2;
    in_range_s = (bus.instr_addr >= MEM_BASE) && (word_off_s < WORDS_C);
    stage0_s.valid = xfer_s;
    stage0_s.err   = xfer_s & ~in_range_s;
    if (in_range_s) begin
      stage0_s.idx = word_off_s[AW-1:0];
    end else begin
      stage0_s.idx = {AW{1'b0}};
    end
  end

  assign bus.instr_gnt = gnt_s;

  // Response pipeline next state: slots advance one stage every cycle.
  always_comb begin
    slot_d[1] = stage0_s;
    for (int k = 2; k <= int'(LATENCY); k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // Outstanding-count next state: a grant and a response in the same cycle cancel.
  always_comb begin
    case ({xfer_s, rsp_valid_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers: reset drops every in-flight request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= {CW{1'b0}};
      for (int k = 1; k <= int'(LATENCY); k++) begin
        slot_q[k] <= SLOT_IDLE;
      end
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  // The memory is read one stage before the response so its registered
  // output lines up with rvalid; at LATENCY=1 that is the grant cycle itself.
  if (LATENCY == 32'd1) begin : g_rd_now
    assign rd_slot_s = stage0_s;
  end else begin : g_rd_pipe
    assign rd_slot_s = slot_q[int'(LATENCY) - 1];
  end

  assign rsp_valid_s = slot_q[LATENCY].valid;
  assign rsp_err_s   = slot_q[LATENCY].err;

  // Memory read port and response drive; outputs are zero between responses.
  always_comb begin
    if (rd_slot_s.valid && !rd_slot_s.err) begin
      mem_en_o   = 1'b1;
      mem_addr_o = rd_slot_s.idx;
    end else begin
      mem_en_o   = 1'b0;
      mem_addr_o = {AW{1'b0}};
    end

    if (rsp_valid_s) begin
      bus.instr_rvalid = 1'b1;
      bus.instr_err    = rsp_err_s;
      if (rsp_err_s) begin
        bus.instr_rdata = 32'h0000_0000;
      end else begin
        bus.instr_rdata = mem_rdata_i;
      end
    end else begin
      bus.instr_rvalid = 1'b0;
      bus.instr_err    = 1'b0;
      bus.instr_rdata  = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_responder
//   Self-checking bench. Three responders with different parameter sets
//   share one clock and reset:
//     dut0 : MEM_BASE=0,      LATENCY=1, MAX_OUTSTANDING=2
//     dut1 : MEM_BASE=0,      LATENCY=2, MAX_OUTSTANDING=3
//     dut2 : MEM_BASE=0x1000, LATENCY=3, MAX_OUTSTANDING=2
//   Each has its own word-memory model. A scoreboard predicts grant, memory
//   reads and responses every cycle; directed sequences cover single reads,
//   streaming, the outstanding limit, errors, wait states and reset.
// ---------------------------------------------------------------------------
module tb_instr_mem_responder;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   cyc;
  int   men2_hits;

  instr_mem_responder_if bus0 ();
  instr_mem_responder_if bus1 ();
  instr_mem_responder_if bus2 ();

  logic        blk   [3];
  logic        men   [3];
  logic [9:0]  maddr [3];
  logic [31:0] mrd   [3];

  logic        req_w   [3];
  logic        gnt_w   [3];
  logic        rv_w    [3];
  logic        err_w   [3];
  logic [31:0] addr_w  [3];
  logic [31:0] rdata_w [3];

  typedef struct { logic err; logic [31:0] data; int cyc; } exp_t;
  typedef struct { int cyc; logic [9:0] idx; } mrd_t;
  typedef struct { int cyc; logic err; logic [31:0] data; } rv_t;

  exp_t sb  [3][$];
  mrd_t mq  [3][$];
  rv_t  rvl [3][$];

  instr_mem_responder #(.MEM_BASE(32'h0000_0000), .MEM_WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0), .gnt_block_i(blk[0]),
    .mem_en_o(men[0]), .mem_addr_o(maddr[0]), .mem_rdata_i(mrd[0]));
  instr_mem_responder #(.MEM_BASE(32'h0000_0000), .MEM_WORDS(1024), .LATENCY(2), .MAX_OUTSTANDING(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1), .gnt_block_i(blk[1]),
    .mem_en_o(men[1]), .mem_addr_o(maddr[1]), .mem_rdata_i(mrd[1]));
  instr_mem_responder #(.MEM_BASE(32'h0000_1000), .MEM_WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2), .gnt_block_i(blk[2]),
    .mem_en_o(men[2]), .mem_addr_o(maddr[2]), .mem_rdata_i(mrd[2]));

  assign req_w[0] = bus0.instr_req;    assign req_w[1] = bus1.instr_req;    assign req_w[2] = bus2.instr_req;
  assign gnt_w[0] = bus0.instr_gnt;    assign gnt_w[1] = bus1.instr_gnt;    assign gnt_w[2] = bus2.instr_gnt;
  assign rv_w[0]  = bus0.instr_rvalid; assign rv_w[1]  = bus1.instr_rvalid; assign rv_w[2]  = bus2.instr_rvalid;
  assign err_w[0] = bus0.instr_err;    assign err_w[1] = bus1.instr_err;    assign err_w[2] = bus2.instr_err;
  assign addr_w[0]  = bus0.instr_addr;  assign addr_w[1]  = bus1.instr_addr;  assign addr_w[2]  = bus2.instr_addr;
  assign rdata_w[0] = bus0.instr_rdata; assign rdata_w[1] = bus1.instr_rdata; assign rdata_w[2] = bus2.instr_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: word 3 holds a known instruction, others 0x1000_0000+idx.
  function automatic logic [31:0] memf(input logic [9:0] idx);
    if (idx == 10'd3) return 32'h0051_0513;
    return 32'h1000_0000 + {22'd0, idx};
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int mo_of(input int i);
    case (i)
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int i);
    case (i)
      2:       return 32'h0000_1000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Synchronous read memories, one per responder.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (men[i]) mrd[i] <= memf(maddr[i]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int i, input logic r, input logic [31:0] a, input logic b);
    blk[i] = b;
    case (i)
      0:       begin bus0.instr_req = r; bus0.instr_addr = a; end
      1:       begin bus1.instr_req = r; bus1.instr_addr = a; end
      default: begin bus2.instr_req = r; bus2.instr_addr = a; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: predicts gnt, memory reads and responses on every cycle.
  initial begin
    logic        eg;
    logic        inr;
    logic [31:0] offs;
    logic [31:0] widx;
    exp_t        e;
    mrd_t        m;
    rv_t         r;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rstn) begin
          sb[i].delete();
          mq[i].delete();
        end else begin
          eg = req_w[i] & ~blk[i] & (sb[i].size() < mo_of(i));
          chk($sformatf("gnt_model%0d", i), {31'd0, gnt_w[i]}, {31'd0, eg});
          if (req_w[i] && gnt_w[i]) begin
            offs  = addr_w[i] - base_of(i);
            widx  = offs >> 2;
            inr   = (addr_w[i] >= base_of(i)) && (widx < 32'd1024);
            e.err  = ~inr;
            e.data = inr ? memf(widx[9:0]) : 32'h0;
            e.cyc  = cyc + lat_of(i);
            sb[i].push_back(e);
            if (inr) begin
              m.cyc = cyc + lat_of(i) - 1;
              m.idx = widx[9:0];
              mq[i].push_back(m);
            end
          end
          if (mq[i].size() > 0 && mq[i][0].cyc == cyc) begin
            chk($sformatf("mem_en%0d", i), {31'd0, men[i]}, 32'd1);
            chk($sformatf("mem_addr%0d", i), {22'd0, maddr[i]}, {22'd0, mq[i][0].idx});
            void'(mq[i].pop_front());
          end else begin
            chk($sformatf("mem_en_idle%0d", i), {31'd0, men[i]}, 32'd0);
          end
          if (i == 2 && men[i]) men2_hits++;
          if (rv_w[i]) begin
            r.cyc = cyc; r.err = err_w[i]; r.data = rdata_w[i];
            rvl[i].push_back(r);
            if (sb[i].size() == 0) begin
              chk($sformatf("rvalid_unexpected%0d", i), 32'd1, 32'd0);
            end else begin
              e = sb[i].pop_front();
              chk($sformatf("rsp_cycle%0d", i), cyc, e.cyc);
              chk($sformatf("rsp_err%0d", i), {31'd0, err_w[i]}, {31'd0, e.err});
              chk($sformatf("rsp_data%0d", i), rdata_w[i], e.data);
            end
          end else begin
            chk($sformatf("idle_err%0d", i), {31'd0, err_w[i]}, 32'd0);
            chk($sformatf("idle_rdata%0d", i), rdata_w[i], 32'd0);
            if (sb[i].size() > 0 && sb[i][0].cyc <= cyc) begin
              chk($sformatf("rvalid_missing%0d", i), 32'd0, 32'd1);
              void'(sb[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic        block;
    logic        exp_gnt;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [9:0]  exp_idx;
  } vec_t;

  vec_t tv [8];
  int   gc [4];
  logic exp_pat [8];

  initial begin
    int gi;
    int budget;
    int nerr;

    tv[0] = '{32'h0000_000C, 1'b0, 1'b1, 1'b0, 32'h0051_0513, 10'd3};
    tv[1] = '{32'h0000_0006, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 10'd1};
    tv[2] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 10'd0};
    tv[3] = '{32'h0000_0FFC, 1'b0, 1'b1, 1'b0, 32'h1000_03FF, 10'd1023};
    tv[4] = '{32'h0000_0FFF, 1'b0, 1'b1, 1'b0, 32'h1000_03FF, 10'd1023};
    tv[5] = '{32'h0000_1000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 10'd0};
    tv[6] = '{32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 10'd0};
    tv[7] = '{32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 10'd0};
    exp_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    checks = 0; errors = 0; men2_hits = 0;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 1'b0);

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_gnt%0d", i),    {31'd0, gnt_w[i]}, 32'd0);
      chk($sformatf("rst_rvalid%0d", i), {31'd0, rv_w[i]},  32'd0);
      chk($sformatf("rst_err%0d", i),    {31'd0, err_w[i]}, 32'd0);
      chk($sformatf("rst_rdata%0d", i),  rdata_w[i],        32'd0);
      chk($sformatf("rst_mem_en%0d", i), {31'd0, men[i]},   32'd0);
    end
    tick();
    rstn = 1'b1;
    tick();

    // Table-driven single reads on dut0 (LATENCY=1)
    for (int v = 0; v < 8; v++) begin
      drive(0, 1'b1, tv[v].addr, tv[v].block);
      @(negedge clk);
      chk($sformatf("tv%0d_gnt", v), {31'd0, gnt_w[0]}, {31'd0, tv[v].exp_gnt});
      chk($sformatf("tv%0d_mem_en", v), {31'd0, men[0]}, {31'd0, tv[v].exp_gnt & ~tv[v].exp_err});
      if (tv[v].exp_gnt && !tv[v].exp_err)
        chk($sformatf("tv%0d_mem_addr", v), {22'd0, maddr[0]}, {22'd0, tv[v].exp_idx});
      tick();
      drive(0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("tv%0d_rvalid", v), {31'd0, rv_w[0]}, {31'd0, tv[v].exp_gnt});
      chk($sformatf("tv%0d_err", v), {31'd0, err_w[0]}, {31'd0, tv[v].exp_err});
      chk($sformatf("tv%0d_rdata", v), rdata_w[0], tv[v].exp_data);
      tick();
    end

    // Wait states with a halfword-aligned address on dut0
    drive(0, 1'b1, 32'h0000_0006, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("blocked_gnt%0d", k), {31'd0, gnt_w[0]}, 32'd0);
      tick();
    end
    drive(0, 1'b1, 32'h0000_0006, 1'b0);
    @(negedge clk);
    chk("unblocked_gnt", {31'd0, gnt_w[0]}, 32'd1);
    tick();
    drive(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("unaligned_rvalid", {31'd0, rv_w[0]}, 32'd1);
    chk("unaligned_rdata", rdata_w[0], 32'h1000_0001);
    tick();

    // Back-to-back streaming on dut1 (LATENCY=2, MAX_OUTSTANDING=3)
    rvl[1].delete();
    gi = 0; budget = 20;
    while (gi < 4 && budget > 0) begin
      drive(1, 1'b1, 32'(gi * 4), 1'b0);
      @(negedge clk);
      if (gnt_w[1]) begin
        gc[gi] = cyc;
        gi++;
      end
      tick();
      budget--;
    end
    drive(1, 1'b0, 32'h0, 1'b0);
    chk("stream_grants", 32'(gi), 32'd4);
    repeat (4) tick();
    chk("stream_rsp_count", 32'(rvl[1].size()), 32'd4);
    if (gi == 4 && rvl[1].size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("stream_gnt_cycle%0d", k), gc[k], gc[0] + k);
        chk($sformatf("stream_rsp_cycle%0d", k), rvl[1][k].cyc, gc[0] + 2 + k);
        chk($sformatf("stream_rsp_data%0d", k), rvl[1][k].data, memf(10'(k)));
      end
    end

    // Outstanding limit on dut2 (LATENCY=3, MAX_OUTSTANDING=2)
    drive(2, 1'b1, 32'h0000_1000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("limit_gnt%0d", k), {31'd0, gnt_w[2]}, {31'd0, exp_pat[k]});
      tick();
    end
    drive(2, 1'b0, 32'h0, 1'b0);
    repeat (5) tick();

    // Error path on dut2: below base and one past the last word
    rvl[2].delete();
    men2_hits = 0;
    drive(2, 1'b1, 32'h0000_0FFC, 1'b0);
    @(negedge clk);
    chk("err_low_gnt", {31'd0, gnt_w[2]}, 32'd1);
    tick();
    drive(2, 1'b1, 32'h0000_2000, 1'b0);
    @(negedge clk);
    chk("err_high_gnt", {31'd0, gnt_w[2]}, 32'd1);
    tick();
    drive(2, 1'b0, 32'h0, 1'b0);
    repeat (5) tick();
    chk("err_mem_en_hits", 32'(men2_hits), 32'd0);
    chk("err_rsp_count", 32'(rvl[2].size()), 32'd2);
    nerr = 0;
    foreach (rvl[2][k]) if (rvl[2][k].err && rvl[2][k].data == 32'h0) nerr++;
    chk("err_rsp_flagged", 32'(nerr), 32'd2);

    // Reset while two requests are in flight on dut2
    drive(2, 1'b1, 32'h0000_1004, 1'b0);
    @(negedge clk);
    chk("rstmid_gnt0", {31'd0, gnt_w[2]}, 32'd1);
    tick();
    @(negedge clk);
    chk("rstmid_gnt1", {31'd0, gnt_w[2]}, 32'd1);
    tick();
    drive(2, 1'b0, 32'h0, 1'b0);
    rstn = 1'b0;
    rvl[2].delete();
    @(negedge clk);
    chk("rstmid_rvalid_in_reset", {31'd0, rv_w[2]}, 32'd0);
    tick();
    rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      tick();
    end
    chk("rstmid_no_rsp", 32'(rvl[2].size()), 32'd0);
    drive(2, 1'b1, 32'h0000_1008, 1'b0);
    @(negedge clk);
    chk("rstmid_new_gnt", {31'd0, gnt_w[2]}, 32'd1);
    tick();
    drive(2, 1'b0, 32'h0, 1'b0);
    repeat (5) tick();
    chk("rstmid_new_rsp", 32'(rvl[2].size()), 32'd1);

    for (int i = 0; i < 3; i++)
      chk($sformatf("drained%0d", i), 32'(sb[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
